// File: rtl/mem_pack.sv
// Word-in / byte-out scratch memory: a LANES-byte word is serialised into byte storage one lane per cycle.
// Byte reads have one-cycle latency and are flagged as errors when they hit an unwritten or out-of-range word.
module mem_pack #(
  parameter int LANES   = 4,
  parameter int DEPTH   = 4,
  parameter int WORD_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int BYTE_AW = (LANES * DEPTH > 1) ? $clog2(LANES * DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr,
  input  logic [WORD_AW-1:0]   wr_addr,
  input  logic [8*LANES-1:0]   Indata,
  output logic                 wr_ready,
  output logic                 done,
  output logic [DEPTH-1:0]     word_valid,
  input  logic                 rd,
  input  logic [BYTE_AW-1:0]   addr,
  output logic [7:0]           Dataout,
  output logic                 valid,
  output logic                 rd_err
);

  localparam int CNT_W  = $clog2(LANES);
  localparam int NBYTES = LANES * DEPTH;

  typedef enum logic {IDLE, WRITE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WORD_AW-1:0]   wa_q, wa_d;
  logic [8*LANES-1:0]   data_q, data_d;
  logic                 done_q, done_d;
  logic [DEPTH-1:0]     word_valid_q, word_valid_d;
  logic [7:0]           dataout_q, dataout_d;
  logic                 valid_q, valid_d;
  logic                 rd_err_q, rd_err_d;

  logic [7:0]           mem_q [NBYTES];
  logic                 mem_we;
  logic                 wa_in_range;
  logic [BYTE_AW-1:0]   wr_byte;
  logic                 word_ok;

  assign wa_in_range = int'(wa_q) < DEPTH;
  assign wr_byte     = BYTE_AW'(int'(wa_q) * LANES + int'(cnt_q));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wa_d         = wa_q;
    data_d       = data_q;
    done_d       = 1'b0;
    word_valid_d = word_valid_q;
    mem_we       = 1'b0;
    dataout_d    = dataout_q;
    valid_d      = 1'b0;
    rd_err_d     = 1'b0;
    word_ok      = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr) begin
          state_d = WRITE;
          cnt_d   = '0;
          wa_d    = wr_addr;
          data_d  = Indata;
        end
      end
      WRITE: begin
        // The latched word is shifted so the current lane always sits in the low byte.
        mem_we = wa_in_range;
        data_d = data_q >> 8;
        cnt_d  = cnt_q + CNT_W'(1);
        if (int'(cnt_q) == LANES - 1) begin
          state_d = IDLE;
          done_d  = 1'b1;
          for (int w = 0; w < DEPTH; w++) begin
            if (wa_in_range && int'(wa_q) == w) word_valid_d[w] = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Out-of-range addresses map past the last word, so word_ok stays low for them.
    for (int w = 0; w < DEPTH; w++) begin
      if (int'(addr) / LANES == w) word_ok = word_valid_q[w];
    end

    if (rd) begin
      valid_d = 1'b1;
      if (word_ok) begin
        dataout_d = mem_q[addr];
        rd_err_d  = 1'b0;
      end else begin
        dataout_d = 8'h00;
        rd_err_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      word_valid_q <= '0;
      dataout_q    <= 8'h00;
      valid_q      <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wa_q         <= wa_d;
      data_q       <= data_d;
      done_q       <= done_d;
      word_valid_q <= word_valid_d;
      dataout_q    <= dataout_d;
      valid_q      <= valid_d;
      rd_err_q     <= rd_err_d;
    end
  end

  // Storage is never cleared; a reset edge also suppresses the in-flight lane write.
  always_ff @(posedge clk) begin
    if (rst && mem_we) mem_q[wr_byte] <= data_q[7:0];
  end

  assign wr_ready   = (state_q == IDLE);
  assign done       = done_q;
  assign word_valid = word_valid_q;
  assign Dataout    = dataout_q;
  assign valid      = valid_q;
  assign rd_err     = rd_err_q;

endmodule
